// File: rtl/fp_pkg.sv
// Shared types for the fp exception arbiter slice.
// Holds the handshake state enum and fp word helpers.
package fp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam logic [7:0] FP_EXP_MAX = 8'd255;

  typedef logic [31:0] fp_word_t;

  function automatic logic [7:0] fp_exp(
    input fp_word_t w
  );
    return w[30:23];
  endfunction

endpackage

// File: rtl/over_underflow_detect.sv
// Flags an fp32 operand whose exponent field is
// all ones (overflow) or all zeros (underflow).
module over_underflow_detect
  import fp_pkg::*;
(
  input  fp_word_t op,
  output logic     ovf,
  output logic     unf
);

  logic [7:0] exp_w;

  always_comb begin
    exp_w = fp_exp(op);
    ovf   = (exp_w == FP_EXP_MAX);
    unf   = (exp_w == 8'd0);
  end

endmodule

// File: rtl/fp_exc_arbiter.sv
// Round-robin two-requester arbiter feeding an fp32
// exception classifier with sticky flags and counters.
module fp_exc_arbiter
  import fp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_src,
  output logic [31:0]      res_data,
  output logic             res_overflow,
  output logic             res_underflow,
  output logic             sticky_ovf,
  output logic             sticky_unf,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt,
  input  logic             clear
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             src_q, src_d;
  fp_word_t         data_q, data_d;
  logic             sovf_q, sovf_d;
  logic             sunf_q, sunf_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic [CNT_W-1:0] ucnt_q, ucnt_d;

  logic gnt;
  logic grant_en;
  logic accept;
  logic det_ovf;
  logic det_unf;

  over_underflow_detect u_det (
    .op  (data_q),
    .ovf (det_ovf),
    .unf (det_unf)
  );

  // Flags only mean something while a result is held.
  always_comb begin
    res_valid     = (state_q == RESP);
    res_src       = src_q;
    res_data      = data_q;
    res_overflow  = res_valid && det_ovf;
    res_underflow = res_valid && det_unf;
    sticky_ovf    = sovf_q;
    sticky_unf    = sunf_q;
    ovf_cnt       = ocnt_q;
    unf_cnt       = ucnt_q;
  end

  always_comb begin
    gnt      = (req0_valid && req1_valid) ? ~last_q
                                          : ~req0_valid;
    grant_en = rst_n && (state_q == IDLE)
               && (req0_valid || req1_valid);
    accept   = (state_q == RESP) && res_ready;

    req0_ready = grant_en && !gnt;
    req1_ready = grant_en && gnt;

    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    data_d  = data_q;
    sovf_d  = sovf_q;
    sunf_d  = sunf_q;
    ocnt_d  = ocnt_q;
    ucnt_d  = ucnt_q;

    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          state_d = RESP;
          last_d  = gnt;
          src_d   = gnt;
          data_d  = gnt ? req1_data : req0_data;
        end
      end
      RESP: begin
        if (accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      sovf_d = sovf_q | res_overflow;
      sunf_d = sunf_q | res_underflow;
      if (res_overflow && ocnt_q != CNT_MAX)
        ocnt_d = ocnt_q + 1'b1;
      if (res_underflow && ucnt_q != CNT_MAX)
        ucnt_d = ucnt_q + 1'b1;
    end

    if (clear) begin
      sovf_d = 1'b0;
      sunf_d = 1'b0;
      ocnt_d = '0;
      ucnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      src_q   <= 1'b0;
      data_q  <= '0;
      sovf_q  <= 1'b0;
      sunf_q  <= 1'b0;
      ocnt_q  <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      data_q  <= data_d;
      sovf_q  <= sovf_d;
      sunf_q  <= sunf_d;
      ocnt_q  <= ocnt_d;
      ucnt_q  <= ucnt_d;
    end
  end

endmodule

// File: doc/fp_exc_arbiter.md
FP_EXC_ARBITER -- requirements
Module: fp_exc_arbiter

Interface
REQ-001 Parameter CNT_W, default 8: width of the saturating exception event counters.
REQ-002 clk  input  1  single clock; every flop is rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester has an operand pending.
REQ-005 req0_data / req1_data  input  32 each  IEEE-754 single-precision operand.
REQ-006 req0_ready / req1_ready  output  1 each  operand accepted this cycle.
REQ-007 res_valid  output  1  classification result available.
REQ-008 res_ready  input  1  consumer accepts the result.
REQ-009 res_src  output  1  requester index of the current result.
REQ-010 res_data  output  32  operand that produced the result.
REQ-011 res_overflow / res_underflow  output  1 each  classifier flags for res_data.
REQ-012 sticky_ovf / sticky_unf  output  1 each  accumulated flags since the last clear.
REQ-013 ovf_cnt / unf_cnt  output  CNT_W each  accepted-result event counts.
REQ-014 clear  input  1  synchronous clear of sticky flags and counters.

Function
REQ-015 The FSM SHALL have two states: IDLE and RESP.
REQ-016 In IDLE with at least one reqN_valid high, the block SHALL assert exactly one reqN_ready combinationally, capture that reqN_data and the index, and move to RESP.
REQ-017 Arbitration SHALL be round-robin: if both requests are valid, grant the requester not granted last; if one is valid, grant it.
REQ-018 The last-grant pointer SHALL update only on an accepted grant.
REQ-019 In RESP the block SHALL hold res_valid=1 and keep res_src, res_data, res_overflow, and res_underflow stable until res_ready=1.
REQ-020 In RESP, reqN_ready SHALL be 0.
REQ-021 res_overflow SHALL equal (exp==255); res_underflow SHALL equal (exp==0). Both flags come from the registered operand.
REQ-022 Latency SHALL be one cycle: res_valid rises on the edge following the grant.
REQ-023 Throughput SHALL be at most one result per two cycles, with no grant in the res_ready cycle.
REQ-024 On the res_valid&&res_ready cycle, the block SHALL return to IDLE.
REQ-025 On that same cycle, sticky_ovf |= res_overflow and sticky_unf |= res_underflow.
REQ-026 On that same cycle, each counter SHALL increment by its flag.
REQ-027 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 When clear=1, the sticky flags and counters SHALL become 0 on the next edge.
REQ-029 If clear and an accepted result coincide, clear SHALL win and that result SHALL NOT be counted.
REQ-030 Deasserting reqN_valid in IDLE without a grant SHALL be legal.
REQ-031 Asserting res_ready while res_valid=0 SHALL have no effect.

Reset
REQ-032 When rst_n=0, the state SHALL become IDLE and the last-grant pointer SHALL be 1, so req0 wins first.
REQ-033 Under reset: res_valid=0; res_src=0; res_data=0; res_overflow=0; res_underflow=0; sticky flags=0; counters=0; reqN_ready=0.
REQ-034 Reset asserted mid-RESP SHALL discard the pending result without updating sticky flags or counters.
REQ-035 After rst_n is released, the first grant SHALL occur no earlier than the first rising edge.

Structure
REQ-036 A shared package fp_pkg SHALL hold the state enum (IDLE, RESP), FP_EXP_MAX=255, and the 32-bit fp word typedef.
REQ-037 The block SHALL instantiate one over_underflow_detect on the registered operand to produce res_overflow and res_underflow.
REQ-038 The block SHALL contain no other sub-modules.

Verification
REQ-039 Scenario: single requester. req0 presents 0x7F800000 with res_ready=1 -> req0_ready in cycle 0; res_valid in cycle 1 with res_src=0, overflow=1, underflow=0; ovf_cnt=1.
REQ-040 Scenario: contention. Both requests held valid, req1 data 0x00000001, res_ready=1 -> grants alternate 0,1,0,1; req1 results show underflow=1.
REQ-041 Scenario: backpressure. res_ready=0 for 5 cycles -> res_* stable, no new grant, counters unchanged until the accepting cycle.
REQ-042 Scenario: saturation. CNT_W=2, 5 accepted overflow results -> ovf_cnt=3.
REQ-043 Scenario: clear collision. clear=1 coincides with an accepted 0x00000000 -> unf_cnt=0 and sticky_unf=0 next cycle.
REQ-044 Scenario: reset mid-RESP. rst_n pulsed low in RESP -> res_valid=0, counters=0, req0 wins the next contention.
